sop_scan_ctrl: RTL and testbench
================================

Name: sop_scan_ctrl

Overview:
- Sequencer that exhaustively drives all 16 input vectors {p,q,r,s} into the team's 4-input SOP function block (t = rs' + pq'r's).
- Waits a programmable settle time per vector, samples t, and assembles the 16-entry truth table.
- Reports the ones-count and a pass/fail compare against a golden table.
- Sits beside the combinational function block as its bring-up and self-check controller.

Parameters:
- SETTLE, 2: cycles each vector is held before t is sampled; legal range 1..15, and 0 is illegal (elaboration error).
- EXPECTED, 16'h4644: golden truth table; bit i corresponds to index i = {p,q,r,s}, so minterms are 2, 6, 9, 10, 14.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  level-sampled; starts a scan when the block is in IDLE.
- abort  in  1  cancels a scan in progress.
- ack  in  1  acknowledges the result; releases DONE.
- t  in  1  output of the SOP function block under control.
- p, q, r, s  out  1 each  vector driven to the function block.
- busy  out  1  high in SCAN.
- done  out  1  high in DONE; results are stable while it is high.
- table  out  16  captured truth table.
- ones  out  5  number of 1 entries in table (0..16).
- match  out  1  (table == EXPECTED); valid only while done is high, otherwise 0.
- err_idx  out  4  first mismatching index (see Optional Feature).
- err_valid  out  1  at least one mismatch was seen in the last scan.

Behaviour:
- Reset:
  - state = IDLE.
  - p, q, r, s, busy, done, match, err_valid = 0.
  - table = 16'h0, ones = 0, err_idx = 0.
  - Internal idx = 0, settle_cnt = 0.
  - Reset asserted mid-scan returns the block to IDLE immediately and discards all partial results.
- States:
  - IDLE:
    - start = 1 at edge E0 → SCAN.
    - At E0: idx = 0, settle_cnt = 0, table = 0, ones = 0, err_valid = 0, err_idx = 0.
  - SCAN:
    - {p,q,r,s} = idx, driven from registers so they are glitch-free.
    - Each edge, with abort = 0:
      - If settle_cnt == SETTLE-1: table[idx] <= t; ones <= ones + t; settle_cnt <= 0.
      - If idx == 15 on that sample edge → DONE; otherwise idx <= idx + 1.
      - Otherwise settle_cnt <= settle_cnt + 1.
    - Vector idx is held for exactly SETTLE cycles. t is sampled at the end of the last of those cycles.
    - abort = 1 → IDLE on the next edge:
      - done is not asserted.
      - p, q, r, s are cleared to 0.
      - table and ones keep their partial values until the next start.
  - DONE:
    - done = 1; table, ones, match, err_* are frozen.
    - ack = 1 → IDLE on the next edge.
    - p, q, r, s are held at 4'b1111 until IDLE, then return to 0.
- Latency: done rises at edge E0 + 16*SETTLE. Example: SETTLE = 2 gives 32 cycles after the start edge.
- Simultaneous events:
  - start during SCAN or DONE is ignored.
  - ack during IDLE or SCAN is ignored.
  - In DONE, start and ack together: ack wins and the state goes to IDLE. The start is not latched; it is re-evaluated in IDLE on the following edge if still high.
  - abort has priority over a sample on the same edge: no table update, state → IDLE.
- Width rules:
  - ones is 5 bits; 16 is representable, so there is no overflow.
  - settle_cnt is 4 bits; idx is 4 bits and never wraps inside a scan.

Optional Feature:
- Macro: SOP_SCAN_ERR_CAPTURE_EN.
- Defined:
  - On each sample where t != EXPECTED[idx] and err_valid == 0, set err_idx <= idx and err_valid <= 1.
  - This captures the first failing vector; both outputs are cleared on start.
- Undefined:
  - err_idx and err_valid are tied to 0. The ports remain present so the interface is identical in both builds.
  - match is unaffected in both builds.

Decomposition:
- Package sop_pkg holds:
  - state encoding constants: IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  - SOP_GOLDEN = 16'h4644;
  - IDX_W = 4 and ONES_W = 5.
- One natural sub-module: sop_settle_timer, holding the settle counter with clear and enable inputs and a terminal-count output.
- The function block itself is instantiated only in the bench, never inside the controller.

Test Plan:
1. SOP function block connected, SETTLE = 2, start pulsed one cycle → done after 32 cycles; table = 16'h4644, ones = 5, match = 1, err_valid = 0.
2. t tied to 0, macro defined → table = 0, ones = 0, match = 0, err_valid = 1, err_idx = 2.
3. t tied to 1, macro undefined → table = 16'hFFFF, ones = 16, match = 0, err_idx = 0, err_valid = 0.
4. SETTLE = 1 → done exactly 16 cycles after the start edge; during SCAN, {p,q,r,s} steps 0 to 15 one per cycle.
5. abort asserted while idx = 7 → IDLE next edge, done never rises, table[15:7] = 0. Then start again → full table = 16'h4644.
6. Interlock and reset cases:
   - rst asserted mid-scan → all outputs 0 asynchronously.
   - start held through the whole scan and DONE → exactly one scan completes before ack.
   - ack with start high in DONE → IDLE first, then a new scan starts on the next edge.

Source files
------------

// File: rtl/sop_pkg.sv
// rtl/sop_pkg.sv - shared types and constants for the SOP scan controller
package sop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] SOP_GOLDEN = 16'h4644;
  localparam int          IDX_W      = 4;
  localparam int          ONES_W     = 5;
  localparam int          CNT_W      = 4;

endpackage

// File: rtl/sop_settle_timer.sv
// rtl/sop_settle_timer.sv - per-vector settle counter with terminal count
module sop_settle_timer
  import sop_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sop_scan_ctrl.sv
// rtl/sop_scan_ctrl.sv - exhaustive truth-table scan of a 4-input SOP block
// Optional first-mismatch capture: SOP_SCAN_ERR_CAPTURE_EN
module sop_scan_ctrl
  import sop_pkg::*;
#(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = SOP_GOLDEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              ack_i,
  input  logic              t_i,
  output logic              p_o,
  output logic              q_o,
  output logic              r_o,
  output logic              s_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       table_o,
  output logic [ONES_W-1:0] ones_o,
  output logic              match_o,
  output logic [IDX_W-1:0]  err_idx_o,
  output logic              err_valid_o
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("sop_scan_ctrl: SETTLE must be within 1..15");
    end
  endgenerate

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  vec_q;
  logic [15:0]       table_q;
  logic [15:0]       table_d;
  logic [ONES_W-1:0] ones_q;
  logic              busy_q;
  logic              done_q;
  logic              match_q;
  logic              tc;
  logic              sample;
  logic              scan_start;

  sop_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != SCAN),
    .en_i  (state_q == SCAN),
    .tc_o  (tc)
  );

  // abort outranks a sample landing on the same edge
  assign sample     = (state_q == SCAN) && !abort_i && tc;
  assign scan_start = (state_q == IDLE) && start_i;

  always_comb begin
    table_d         = table_q;
    table_d[idx_q]  = t_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            vec_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
          end
        end
        SCAN: begin
          if (abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end else if (tc) begin
            table_q <= table_d;
            ones_q  <= ones_q + ONES_W'(t_i);
            if (idx_q == '1) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (table_d == EXPECTED);
            end else begin
              idx_q <= idx_q + 1'b1;
              vec_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (ack_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            vec_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          match_q <= 1'b0;
          vec_q   <= '0;
        end
      endcase
    end
  end

`ifdef SOP_SCAN_ERR_CAPTURE_EN
  logic [IDX_W-1:0] err_idx_q;
  logic             err_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_idx_q   <= '0;
      err_valid_q <= 1'b0;
    end else if (scan_start) begin
      err_idx_q   <= '0;
      err_valid_q <= 1'b0;
    end else if (sample && (t_i != EXPECTED[idx_q]) && !err_valid_q) begin
      err_idx_q   <= idx_q;
      err_valid_q <= 1'b1;
    end
  end

  assign err_idx_o   = err_idx_q;
  assign err_valid_o = err_valid_q;
`else
  assign err_idx_o   = '0;
  assign err_valid_o = 1'b0;
`endif

  assign {p_o, q_o, r_o, s_o} = vec_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign table_o              = table_q;
  assign ones_o               = ones_q;
  assign match_o              = match_q;

endmodule

// File: tb/tb_sop_scan_ctrl.sv
// tb/tb_sop_scan_ctrl.sv - self-checking bench for sop_scan_ctrl (SETTLE 2 and 1)
module tb_sop_scan_ctrl;

  localparam logic [15:0] GOLDEN = 16'h4644;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: SETTLE = 2
  logic        start_a = 1'b0, abort_a = 1'b0, ack_a = 1'b0, t_a;
  logic        p_a, q_a, r_a, s_a, busy_a, done_a, match_a, errv_a;
  logic [15:0] tbl_a;
  logic [4:0]  ones_a;
  logic [3:0]  erri_a;
  logic [3:0]  vec_a;
  int          mode_a = 0;
  logic [15:0] rtbl = 16'h0;

  // instance B: SETTLE = 1, always fed by the real function block
  logic        start_b = 1'b0, abort_b = 1'b0, ack_b = 1'b0, t_b;
  logic        p_b, q_b, r_b, s_b, busy_b, done_b, match_b, errv_b;
  logic [15:0] tbl_b;
  logic [4:0]  ones_b;
  logic [3:0]  erri_b;
  logic [3:0]  vec_b;

  function automatic logic sop_f(input logic [3:0] v);
    return (v[1] & ~v[0]) | (v[3] & ~v[2] & ~v[1] & v[0]);
  endfunction

  assign vec_a = {p_a, q_a, r_a, s_a};
  assign vec_b = {p_b, q_b, r_b, s_b};
  assign t_b   = sop_f(vec_b);

  always_comb begin
    case (mode_a)
      0:       t_a = sop_f(vec_a);
      1:       t_a = 1'b0;
      2:       t_a = 1'b1;
      default: t_a = rtbl[vec_a];
    endcase
  end

  sop_scan_ctrl #(.SETTLE(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a), .ack_i(ack_a), .t_i(t_a),
    .p_o(p_a), .q_o(q_a), .r_o(r_a), .s_o(s_a), .busy_o(busy_a), .done_o(done_a),
    .table_o(tbl_a), .ones_o(ones_a), .match_o(match_a), .err_idx_o(erri_a), .err_valid_o(errv_a)
  );

  sop_scan_ctrl #(.SETTLE(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_b), .ack_i(ack_b), .t_i(t_b),
    .p_o(p_b), .q_o(q_b), .r_o(r_b), .s_o(s_b), .busy_o(busy_b), .done_o(done_b),
    .table_o(tbl_b), .ones_o(ones_b), .match_o(match_b), .err_idx_o(erri_b), .err_valid_o(errv_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Truth table the scan should record for a given t source
  function automatic logic [15:0] model_table(input int mode, input logic [15:0] r);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       m[i] = sop_f(4'(i));
        1:       m[i] = 1'b0;
        2:       m[i] = 1'b1;
        default: m[i] = r[i];
      endcase
    end
    return m;
  endfunction

  task automatic check_result_a(input string tag, input int mode);
    logic [15:0] et;
    logic        ev;
    logic [3:0]  ei;
    et = model_table(mode, rtbl);
    ev = 1'b0;
    ei = 4'd0;
`ifdef SOP_SCAN_ERR_CAPTURE_EN
    for (int i = 0; i < 16; i++) begin
      if (!ev && et[i] != GOLDEN[i]) begin
        ev = 1'b1;
        ei = 4'(i);
      end
    end
`endif
    chk({tag, ".table"}, tbl_a, et);
    chk({tag, ".ones"}, ones_a, $countones(et));
    chk({tag, ".match"}, match_a, et == GOLDEN);
    chk({tag, ".err_valid"}, errv_a, ev);
    chk({tag, ".err_idx"}, erri_a, ei);
    chk({tag, ".vec_done"}, vec_a, 4'hF);
  endtask

  task automatic run_a(input string tag, input int mode);
    int n;
    mode_a  = mode;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk({tag, ".busy"}, busy_a, 1'b1);
    n = 0;
    while (!done_a && n < 100) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, n, 32);
    check_result_a(tag, mode);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    chk({tag, ".ack_done"}, done_a, 1'b0);
    chk({tag, ".ack_match"}, match_a, 1'b0);
    chk({tag, ".ack_vec"}, vec_a, 4'h0);
  endtask

  initial begin
    int  n;
    logic seen;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy_a, 0);
    chk("rst.done", done_a, 0);
    chk("rst.table", tbl_a, 0);
    chk("rst.ones", ones_a, 0);
    chk("rst.match", match_a, 0);
    chk("rst.err_valid", errv_a, 0);
    chk("rst.err_idx", erri_a, 0);
    chk("rst.vec", vec_a, 0);
    chk("rst.vec_b", vec_b, 0);
    rst = 1'b0;
    step();

    run_a("sop", 0);
    run_a("zero", 1);
    run_a("ones", 2);
    for (int k = 0; k < 5; k++) begin
      rtbl = 16'($urandom);
      run_a($sformatf("rand%0d", k), 3);
    end

    // ack during SCAN is ignored
    mode_a  = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (3) step();
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    chk("ack_in_scan.busy", busy_a, 1'b1);
    n = 0;
    while (!done_a && n < 100) begin
      step();
      n++;
    end
    chk("ack_in_scan.latency", n, 28);
    check_result_a("ack_in_scan", 0);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;

    // SETTLE = 1: one vector per cycle, done 16 edges after start
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("s1.vec%0d", k), vec_b, k);
      chk($sformatf("s1.done%0d", k), done_b, 0);
      step();
    end
    chk("s1.done", done_b, 1'b1);
    chk("s1.table", tbl_b, GOLDEN);
    chk("s1.ones", ones_b, 5);
    chk("s1.match", match_b, 1'b1);
    ack_b = 1'b1;
    step();
    ack_b = 1'b0;
    chk("s1.ack", done_b, 1'b0);

    // abort while idx = 7, between samples
    mode_a  = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (14) step();
    chk("abort.vec7", vec_a, 4'd7);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort.busy", busy_a, 1'b0);
    chk("abort.vec", vec_a, 4'd0);
    chk("abort.table", tbl_a, model_table(0, 16'h0) & 16'h007F);
    chk("abort.ones", ones_a, 2);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= done_a;
    end
    chk("abort.no_done", seen, 1'b0);
    run_a("after_abort", 0);

    // abort on the sample edge of idx 7 wins over the sample
    mode_a  = 2;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (15) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort_sample.table", tbl_a, 16'h007F);
    chk("abort_sample.ones", ones_a, 7);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("restart.table", tbl_a, 0);
    chk("restart.ones", ones_a, 0);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;

    // asynchronous reset mid-scan
    mode_a  = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", busy_a, 0);
    chk("rst_mid.vec", vec_a, 0);
    chk("rst_mid.table", tbl_a, 0);
    chk("rst_mid.ones", ones_a, 0);
    chk("rst_mid.done", done_a, 0);
    step();
    rst = 1'b0;
    step();

    // start held through scan and DONE: single scan, then ack wins over start
    mode_a  = 0;
    start_a = 1'b1;
    step();
    n = 0;
    while (!done_a && n < 100) begin
      step();
      n++;
    end
    chk("hold.latency", n, 32);
    seen = 1'b0;
    repeat (5) begin
      step();
      seen |= (!done_a) | busy_a | (tbl_a != GOLDEN);
    end
    chk("hold.stable", seen, 1'b0);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    chk("ack_start.done", done_a, 1'b0);
    chk("ack_start.idle", busy_a, 1'b0);
    step();
    start_a = 1'b0;
    chk("ack_start.rescan", busy_a, 1'b1);
    chk("ack_start.cleared", tbl_a, 0);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("final.idle", busy_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
